// File: rtl/if_stage.sv
// Instruction fetch: owns the PC, runs a req/ack fetch to instruction memory and
// feeds the IF/ID register, with a one-entry skid buffer that absorbs the word returned during a stall.
module if_stage #(
  parameter logic [31:0] RESET_PC  = 32'h0000_0000,
  parameter logic [31:0] NOP_INSTR = 32'h0000_0000
) (
  input  logic        clk,
  input  logic        rst_n,
  output logic        imem_req,
  output logic [31:0] imem_addr,
  input  logic        imem_ack,
  input  logic [31:0] imem_rdata,
  input  logic        stall,
  input  logic        redirect_en,
  input  logic [31:0] redirect_pc,
  output logic [31:0] IF_ID_instr,
  output logic [31:0] IF_ID_pc4,
  output logic        IF_ID_valid,
  output logic [5:0]  Opcode
);

  typedef enum logic [1:0] {FETCH, HOLD, KILL} state_t;

  state_t      r_state;
  logic [31:0] r_pc;
  logic [31:0] r_kill_addr;
  logic        r_req;
  logic [31:0] r_instr;
  logic [31:0] r_pc4;
  logic        r_valid;
  logic [31:0] r_buf_instr;
  logic [31:0] r_buf_pc4;

  logic        w_ack;
  logic [31:0] w_pc4;
  logic [31:0] w_target;
  logic        w_unused_bits;

  // An ack only counts against a request that is actually outstanding.
  assign w_ack         = imem_ack & r_req;
  assign w_pc4         = r_pc + 32'd4;
  assign w_target      = {redirect_pc[31:2], 2'b00};
  assign w_unused_bits = ^redirect_pc[1:0];

  assign imem_req    = r_req;
  assign imem_addr   = (r_state == KILL) ? r_kill_addr : r_pc;
  assign IF_ID_instr = r_instr;
  assign IF_ID_pc4   = r_pc4;
  assign IF_ID_valid = r_valid;
  assign Opcode      = r_instr[31:26];

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state     <= FETCH;
      r_pc        <= RESET_PC;
      r_kill_addr <= RESET_PC;
      r_req       <= 1'b0;
      r_instr     <= NOP_INSTR;
      r_pc4       <= 32'h0;
      r_valid     <= 1'b0;
      r_buf_instr <= NOP_INSTR;
      r_buf_pc4   <= 32'h0;
    end else begin
      r_req <= 1'b1;
      if (redirect_en) begin
        r_valid     <= 1'b0;
        r_instr     <= NOP_INSTR;
        r_buf_instr <= NOP_INSTR;
        r_buf_pc4   <= 32'h0;
        r_pc        <= w_target;
        // An unacked request cannot be withdrawn; wait it out in KILL.
        if (r_req && !w_ack) begin
          if (r_state != KILL) r_kill_addr <= r_pc;
          r_state <= KILL;
        end else begin
          r_state <= FETCH;
        end
      end else begin
        case (r_state)
          FETCH: begin
            if (stall) begin
              if (w_ack) begin
                r_buf_instr <= imem_rdata;
                r_buf_pc4   <= w_pc4;
                r_pc        <= w_pc4;
                r_req       <= 1'b0;
                r_state     <= HOLD;
              end
            end else if (w_ack) begin
              r_instr <= imem_rdata;
              r_pc4   <= w_pc4;
              r_valid <= 1'b1;
              r_pc    <= w_pc4;
            end else begin
              r_instr <= NOP_INSTR;
              r_valid <= 1'b0;
            end
          end
          HOLD: begin
            if (stall) begin
              r_req <= 1'b0;
            end else begin
              r_instr     <= r_buf_instr;
              r_pc4       <= r_buf_pc4;
              r_valid     <= 1'b1;
              r_buf_instr <= NOP_INSTR;
              r_buf_pc4   <= 32'h0;
              r_state     <= FETCH;
            end
          end
          KILL: begin
            if (w_ack) r_state <= FETCH;
          end
          default: r_state <= FETCH;
        endcase
      end
    end
  end

endmodule
